// File: rtl/cpu_ram_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ram_pkg
// Shared types and constants for the CPU RAM responder slice.
//   state_e      : responder FSM state (LOAD = loader owns memory, RUN = CPU owns)
//   DEF_*        : default geometry of the 16-bit accumulator CPU memory
//   even_parity  : even-parity bit over a zero-extended word (used only when
//                  the PARITY_CHECK_EN build option is defined)
// -----------------------------------------------------------------------------
package cpu_ram_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8192;

  // Widest word the parity helper accepts; callers zero-extend into it, which
  // leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 64;

  // Returns the bit that makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cpu_ram_array.sv
// -----------------------------------------------------------------------------
// cpu_ram_array
// Single-port synchronous block RAM, read-first. Every cycle the word at
// addr_i is registered onto rdata_o; when we_i is high the same address is
// written, and the read returns the contents from before that write.
// Contents are not reset.
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   word index (IDX_W bits)
//   wdata_i  write word (WIDTH bits)
//   rdata_o  registered read word (WIDTH bits)
// -----------------------------------------------------------------------------
module cpu_ram_array
  import cpu_ram_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read and write share one edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_ram_responder.sv
// -----------------------------------------------------------------------------
// cpu_ram_responder
// Memory-side responder for the 16-bit accumulator CPU. After reset it sits in
// LOAD: the loader port fills memory while the CPU is held in reset. An
// ld_done pulse moves it to RUN, where the CPU gets a plain synchronous RAM
// with a 1-cycle read latency (read every cycle, read-first on collisions).
// Out-of-range accesses are dropped/return 0 and set the sticky err flag.
//
// Build option: PARITY_CHECK_EN
//   defined   -> each word carries an even-parity bit, checked on every RUN
//                read; adds input inj_parity_flip to corrupt stored parity.
//   undefined -> no parity storage and no inj_parity_flip port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_wrEn          CPU write enable
//   cpu_addr          CPU word address
//   cpu_wdata         CPU write data
//   cpu_rdata         registered read data to the CPU (0 outside RUN reads)
//   cpu_rst           hold-reset to the CPU, high while loading
//   ld_valid/ld_ready loader handshake
//   ld_addr, ld_data  loader word address / data
//   ld_done           end-of-load pulse
//   load_count        loader words accepted since reset (saturating)
//   err               sticky error flag (range, protocol, parity)
//   inj_parity_flip   (PARITY_CHECK_EN only) invert stored parity on write
// -----------------------------------------------------------------------------
module cpu_ram_responder
  import cpu_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err
`ifdef PARITY_CHECK_EN
  ,
  input  logic              inj_parity_flip
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PARITY_CHECK_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;

  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e          state_q;
  logic            cpu_rst_q;
  logic            ld_ready_q;
  logic            err_q;
  logic            rd_valid_q;   // last registered read was an in-range RUN read
  logic [ADDR_W:0] load_count_q;

  logic              ld_xfer;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr_req;
  logic              mem_we;
  logic              addr_oor;
  logic              par_err;
  logic [MEM_W-1:0]  mem_wword;
  logic [MEM_W-1:0]  mem_rword;

  // Port mux: the loader owns the array in LOAD, the CPU in RUN.
  always_comb begin
    ld_xfer = (state_q == LOAD) && ld_valid && ld_ready_q;
    if (state_q == LOAD) begin
      mem_addr   = ld_addr;
      mem_wdata  = ld_data;
      mem_wr_req = ld_xfer;
    end else begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_wr_req = cpu_wrEn;
    end
    addr_oor = ({1'b0, mem_addr} >= DEPTH_LIM);
    // A write coinciding with rst never reaches the array.
    mem_we   = mem_wr_req && !addr_oor && !rst;
  end

`ifdef PARITY_CHECK_EN
  assign mem_wword = {even_parity(PAR_MAX_W'(mem_wdata)) ^ inj_parity_flip, mem_wdata};
  // Checked against the word currently on cpu_rdata, so err rises with it.
  assign par_err   = rd_valid_q &&
                     (mem_rword[DATA_W] != even_parity(PAR_MAX_W'(mem_rword[DATA_W-1:0])));
`else
  assign mem_wword = mem_wdata;
  assign par_err   = 1'b0;
`endif

  cpu_ram_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr[IDX_W-1:0]),
    .wdata_i (mem_wword),
    .rdata_o (mem_rword)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      cpu_rst_q    <= 1'b1;
      ld_ready_q   <= 1'b0;
      load_count_q <= '0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          rd_valid_q <= 1'b0;
          if (ld_xfer && (load_count_q != COUNT_MAX)) begin
            load_count_q <= load_count_q + (ADDR_W+1)'(1);
          end
          if (ld_xfer && addr_oor) begin
            err_q <= 1'b1;
          end
          // A transfer in the ld_done cycle has already been accepted above.
          if (ld_done) begin
            state_q    <= RUN;
            cpu_rst_q  <= 1'b0;
            ld_ready_q <= 1'b0;
          end else begin
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b1;
          end
        end
        RUN: begin
          cpu_rst_q  <= 1'b0;
          ld_ready_q <= 1'b0;
          rd_valid_q <= !addr_oor;
          // Out-of-range covers both the read and any write this cycle.
          if (addr_oor || ld_valid) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
      if (par_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cpu_rdata  = rd_valid_q ? mem_rword[DATA_W-1:0] : '0;
  assign cpu_rst    = cpu_rst_q;
  assign ld_ready   = ld_ready_q;
  assign load_count = load_count_q;
  assign err        = err_q | par_err;

endmodule

// File: tb/tb_cpu_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_ram_responder
// Directed, table-driven bench for cpu_ram_responder (DEPTH = 4096 so that the
// upper half of the 13-bit address space is out of range). Each table row is
// applied for one clock; outputs are compared 1 time unit after the edge.
// Hand-written sequences cover load_count saturation, loader range errors and
// (when PARITY_CHECK_EN is defined) parity error injection.
// -----------------------------------------------------------------------------
module tb_cpu_ram_responder;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cpu_wrEn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic [ADDR_W:0]   load_count;
  logic              err;
`ifdef PARITY_CHECK_EN
  logic              inj_parity_flip;
`endif

  cpu_ram_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_wrEn   (cpu_wrEn),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rst    (cpu_rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .load_count (load_count),
    .err        (err)
`ifdef PARITY_CHECK_EN
    ,
    .inj_parity_flip (inj_parity_flip)
`endif
  );

  typedef struct {
    logic              rst;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ldv;
    logic [ADDR_W-1:0] ldaddr;
    logic [DATA_W-1:0] lddata;
    logic              ldd;
    logic              rdchk;
    logic [DATA_W-1:0] e_rdata;
    logic              e_cpu_rst;
    logic              e_ld_ready;
    logic [ADDR_W:0]   e_cnt;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int r, input int wr, input int a, input int wd,
                              input int lv, input int la, input int ldat, input int ldd,
                              input int rc, input int erd, input int ecr, input int elr,
                              input int ecnt, input int eerr);
    vec_t v;
    v.rst        = 1'(r);
    v.wr         = 1'(wr);
    v.addr       = ADDR_W'(a);
    v.wdata      = DATA_W'(wd);
    v.ldv        = 1'(lv);
    v.ldaddr     = ADDR_W'(la);
    v.lddata     = DATA_W'(ldat);
    v.ldd        = 1'(ldd);
    v.rdchk      = 1'(rc);
    v.e_rdata    = DATA_W'(erd);
    v.e_cpu_rst  = 1'(ecr);
    v.e_ld_ready = 1'(elr);
    v.e_cnt      = (ADDR_W+1)'(ecnt);
    v.e_err      = 1'(eerr);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    cpu_wrEn  = v.wr;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    ld_valid  = v.ldv;
    ld_addr   = v.ldaddr;
    ld_data   = v.lddata;
    ld_done   = v.ldd;
  endtask

  task automatic idle();
    rst       = 1'b0;
    cpu_wrEn  = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ld_done   = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
`ifdef PARITY_CHECK_EN
    inj_parity_flip = 1'b0;
`endif

    //        rst wr addr    wdata   ldv ladr ldata   ldd rc erdata  crst ldr cnt err
    vecs.push_back(mk(1, 0, 0,      0,      0, 0, 0,      0, 1, 0,      1, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0, 1, 0,      1, 1, 0, 0)); // LOAD ready
    vecs.push_back(mk(0, 0, 0,      0,      1, 1, 'hA005, 0, 1, 0,      1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,      0,      1, 2, 'h0007, 0, 1, 0,      1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0,      0,      1, 4, 'h0002, 1, 1, 0,      0, 0, 3, 0)); // xfer + done
    vecs.push_back(mk(0, 0, 2,      0,      0, 0, 0,      0, 1, 'h0007, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1,      0,      0, 0, 0,      0, 1, 'hA005, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 4,      0,      0, 0, 0,      0, 1, 'h0002, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 2,      0,      0, 0, 0,      0, 1, 'h0007, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 5,      'h5555, 0, 0, 0,      0, 0, 0,      0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 5,      'h1234, 0, 0, 0,      0, 1, 'h5555, 0, 0, 3, 0)); // read-first
    vecs.push_back(mk(0, 0, 5,      0,      0, 0, 0,      0, 1, 'h1234, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 1,      0,      0, 0, 0,      0, 1, 'hA005, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 'h0800, 'h0ABC, 0, 0, 0,      0, 0, 0,      0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 'h1800, 'hBEEF, 0, 0, 0,      0, 1, 0,      0, 0, 3, 1)); // OOR write
    vecs.push_back(mk(0, 0, 'h0800, 0,      0, 0, 0,      0, 1, 'h0ABC, 0, 0, 3, 1)); // alias intact
    vecs.push_back(mk(0, 0, 'h1FFF, 0,      0, 0, 0,      0, 1, 0,      0, 0, 3, 1)); // OOR read
    vecs.push_back(mk(1, 1, 1,      'hDEAD, 0, 0, 0,      0, 1, 0,      1, 0, 0, 0)); // rst mid-RUN
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0, 1, 0,      1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      1, 1, 0,      0, 0, 0, 0)); // done, no words
    vecs.push_back(mk(0, 0, 1,      0,      0, 0, 0,      0, 1, 'hA005, 0, 0, 0, 0)); // retained
    vecs.push_back(mk(0, 0, 2,      0,      1, 3, 'hFFFF, 0, 1, 'h0007, 0, 0, 0, 1)); // ld_valid in RUN

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      if (vecs[i].rdchk) chk("cpu_rdata", i, 32'(cpu_rdata), 32'(vecs[i].e_rdata));
      chk("cpu_rst", i, 32'(cpu_rst), 32'(vecs[i].e_cpu_rst));
      chk("ld_ready", i, 32'(ld_ready), 32'(vecs[i].e_ld_ready));
      chk("load_count", i, 32'(load_count), 32'(vecs[i].e_cnt));
      chk("err", i, 32'(err), 32'(vecs[i].e_err));
    end

    // load_count saturates at 2**ADDR_W; last loader write to an index wins.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8193; i++) begin
      ld_valid = 1'b1;
      ld_addr  = ADDR_W'(i % DEPTH);
      ld_data  = DATA_W'(i);
      tick();
      if (i == 8190) chk("sat_cnt_pre", i, 32'(load_count), 32'd8191);
      if (i == 8191) chk("sat_cnt_max", i, 32'(load_count), 32'd8192);
    end
    chk("sat_cnt_hold", 0, 32'(load_count), 32'd8192);
    chk("sat_err", 0, 32'(err), 32'd0);
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    tick();
    ld_done  = 1'b0;
    cpu_addr = ADDR_W'('h123);
    tick();
    chk("sat_readback", 0, 32'(cpu_rdata), 32'h1123);

    // Loader transfer to an out-of-range address sets err.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("ld_oor_err_pre", 0, 32'(err), 32'd0);
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'('h1000);
    ld_data  = DATA_W'('h0001);
    tick();
    ld_valid = 1'b0;
    chk("ld_oor_err", 0, 32'(err), 32'd1);
    tick();
    chk("ld_oor_sticky", 0, 32'(err), 32'd1);

`ifdef PARITY_CHECK_EN
    // Corrupted stored parity is flagged when the word is read, data intact.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'(7);
    ld_data  = DATA_W'('h1111);
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    tick();
    ld_done         = 1'b0;
    cpu_wrEn        = 1'b1;
    cpu_addr        = ADDR_W'(7);
    cpu_wdata       = DATA_W'('h00F0);
    inj_parity_flip = 1'b1;
    tick();
    chk("par_old_data", 0, 32'(cpu_rdata), 32'h1111);
    chk("par_err_pre", 0, 32'(err), 32'd0);
    cpu_wrEn        = 1'b0;
    inj_parity_flip = 1'b0;
    tick();
    chk("par_data", 0, 32'(cpu_rdata), 32'h00F0);
    chk("par_err", 0, 32'(err), 32'd1);
    cpu_addr = ADDR_W'(1);
    tick();
    chk("par_err_sticky", 0, 32'(err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
